// File: rtl/alu_mc.sv
// Multi-cycle integer ALU for the execute stage: registered result, valid/ready
// handshake, iterative shifter that advances SHIFT_STEP bits per cycle.
module alu_mc #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(XLEN)
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_kill,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [XLEN-1:0] i_in_b,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic            i_alu_en,
  input  logic            i_alu_imm,
  output logic            o_valid,
  output logic [XLEN-1:0] o_alu_out,
  output logic            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_t;

  // One bit wider than the shift amount so SHIFT_STEP == XLEN is representable.
  localparam logic [SHAMT_W:0] LP_STEP = (SHAMT_W+1)'(SHIFT_STEP);

  state_t               r_state, w_next;
  shift_t               r_kind, w_kind;
  logic [XLEN-1:0]      r_work, r_alu_out, w_result, w_work_next;
  logic [SHAMT_W-1:0]   r_cnt, w_cnt_next, w_k;
  logic [SHAMT_W:0]     w_step;
  logic                 w_alt, w_is_shift, w_start_shift, w_accept, w_take;

  // Decode of the incoming request; shifts with k == 0 complete like any other op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_k        = i_in_b[SHAMT_W-1:0];
    w_alt      = (i_funct7 == 7'b0100000);
    w_is_shift = 1'b0;
    w_kind     = SH_SLL;
    w_result   = i_in_a + i_in_b;
    if (i_alu_en) begin
      case (i_funct3)
        3'b000:  if (!i_alu_imm && w_alt) w_result = i_in_a - i_in_b;
        3'b010:  w_result = {{(XLEN-1){1'b0}}, ($signed(i_in_a) < $signed(i_in_b))};
        3'b011:  w_result = {{(XLEN-1){1'b0}}, (i_in_a < i_in_b)};
        3'b100:  w_result = i_in_a ^ i_in_b;
        3'b110:  w_result = i_in_a | i_in_b;
        3'b111:  w_result = i_in_a & i_in_b;
        3'b001: begin
          w_is_shift = 1'b1;
          w_kind     = SH_SLL;
          w_result   = i_in_a;
        end
        3'b101: begin
          w_is_shift = 1'b1;
          w_kind     = w_alt ? SH_SRA : SH_SRL;
          w_result   = i_in_a;
        end
        default: w_result = i_in_a + i_in_b;
      endcase
    end
  end

  assign w_start_shift = w_is_shift && (w_k != '0);
  assign w_accept      = i_valid && o_ready;
  assign w_take        = w_accept && !i_kill;

  // One iteration: shift by min(SHIFT_STEP, remaining); the MSB of r_work stays A[XLEN-1] for SRA.
  always_comb begin
    w_step     = ({1'b0, r_cnt} > LP_STEP) ? LP_STEP : {1'b0, r_cnt};
    w_cnt_next = r_cnt - w_step[SHAMT_W-1:0];
    case (r_kind)
      SH_SRL:  w_work_next = r_work >> w_step;
      SH_SRA:  w_work_next = XLEN'($signed(r_work) >>> w_step);
      default: w_work_next = r_work << w_step;
    endcase
  end

  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_take) w_next = w_start_shift ? S_SHIFT : S_DONE;
        else        w_next = S_IDLE;
      end
      S_SHIFT: begin
        if (i_kill)                 w_next = S_IDLE;
        else if (w_cnt_next == '0)  w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state != S_SHIFT);
    o_busy  = (r_state == S_SHIFT);
    o_valid = (r_state == S_DONE);
  end

  assign o_alu_out = r_alu_out;

  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      r_work    <= '0;
      r_cnt     <= '0;
      r_kind    <= SH_SLL;
      r_alu_out <= '0;
    end else if (w_take) begin
      if (w_start_shift) begin
        r_work <= i_in_a;
        r_cnt  <= w_k;
        r_kind <= w_kind;
      end else begin
        r_alu_out <= w_result;
      end
    end else if (r_state == S_SHIFT) begin
      if (i_kill) begin
        r_cnt <= '0;
      end else begin
        r_work <= w_work_next;
        r_cnt  <= w_cnt_next;
        if (w_cnt_next == '0) r_alu_out <= w_work_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: one instance with SHIFT_STEP=1, one with SHIFT_STEP=4.
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        valid1, valid4, kill;
  logic [31:0] in_a, in_b;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        alu_en, alu_imm;
  logic        sel;

  logic        ready1, ovalid1, busy1;
  logic        ready4, ovalid4, busy4;
  logic [31:0] out1, out4;

  logic        m_ready, m_valid, m_busy;
  logic [31:0] m_out;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (
    .i_clk_n(clk), .i_rst(rst), .i_valid(valid1), .o_ready(ready1), .i_kill(kill),
    .i_in_a(in_a), .i_in_b(in_b), .i_funct3(f3), .i_funct7(f7),
    .i_alu_en(alu_en), .i_alu_imm(alu_imm),
    .o_valid(ovalid1), .o_alu_out(out1), .o_busy(busy1)
  );

  alu_mc #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .i_clk_n(clk), .i_rst(rst), .i_valid(valid4), .o_ready(ready4), .i_kill(kill),
    .i_in_a(in_a), .i_in_b(in_b), .i_funct3(f3), .i_funct7(f7),
    .i_alu_en(alu_en), .i_alu_imm(alu_imm),
    .o_valid(ovalid4), .o_alu_out(out4), .o_busy(busy4)
  );

  assign m_ready = sel ? ready4  : ready1;
  assign m_valid = sel ? ovalid4 : ovalid1;
  assign m_busy  = sel ? busy4   : busy1;
  assign m_out   = sel ? out4    : out1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request on the selected instance and wait for its o_valid.
  task automatic exec(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] fn3, input logic [6:0] fn7,
                      input logic en, input logic imm,
                      output logic [31:0] res, output int lat, output int busy_n);
    int guard;
    sel = s; in_a = a; in_b = b; f3 = fn3; f7 = fn7; alu_en = en; alu_imm = imm;
    if (s) valid4 = 1'b1; else valid1 = 1'b1;
    guard = 0;
    while (!m_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_ready", m_ready, 1'b1);
    @(posedge clk); #1;
    valid1 = 1'b0; valid4 = 1'b0;
    lat = 1; busy_n = 0;
    while (!m_valid && lat < 100) begin
      if (m_busy) busy_n++;
      @(posedge clk); #1; lat++;
    end
    res = m_out;
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] fn3, input logic [6:0] fn7, input logic en, input logic imm,
                     input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int lat, busy_n;
    exec(s, a, b, fn3, fn7, en, imm, res, lat, busy_n);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_n, (exp_lat > 1) ? exp_lat - 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nv;
    clk = 0; rst = 1; valid1 = 0; valid4 = 0; kill = 0; sel = 0;
    in_a = 0; in_b = 0; f3 = 0; f7 = 0; alu_en = 1; alu_imm = 0;
    #2;
    check("rst_out1",   out1,    32'h0);
    check("rst_valid1", ovalid1, 1'b0);
    check("rst_busy1",  busy1,   1'b0);
    check("rst_ready1", ready1,  1'b1);
    check("rst_out4",   out4,    32'h0);
    check("rst_ready4", ready4,  1'b1);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // SHIFT_STEP = 1
    run("add_wrap", 0, 32'hFFFF_FFFF, 32'h1, 3'b000, 7'h00, 1, 0, 32'h0000_0000, 1);
    run("sub",      0, 32'h5, 32'h7, 3'b000, 7'h20, 1, 0, 32'hFFFF_FFFE, 1);
    run("addi_f7",  0, 32'h5, 32'h7, 3'b000, 7'h20, 1, 1, 32'h0000_000C, 1);
    run("sra31",    0, 32'h8000_0000, 32'd31, 3'b101, 7'h20, 1, 0, 32'hFFFF_FFFF, 32);
    run("srl31",    0, 32'h8000_0000, 32'd31, 3'b101, 7'h00, 1, 0, 32'h0000_0001, 32);
    run("slt",      0, 32'hFFFF_FFFF, 32'h1, 3'b010, 7'h00, 1, 0, 32'h1, 1);
    run("sltu",     0, 32'hFFFF_FFFF, 32'h1, 3'b011, 7'h00, 1, 0, 32'h0, 1);
    run("force_add",0, 32'h1000, 32'h10, 3'b111, 7'h00, 0, 0, 32'h1010, 1);

    // SHIFT_STEP = 4
    run("sll5",     1, 32'h1, 32'h25, 3'b001, 7'h00, 1, 0, 32'h0000_0020, 3);
    run("sll_k0",   1, 32'h1234, 32'h20, 3'b001, 7'h00, 1, 0, 32'h0000_1234, 1);
    run("srai6",    1, 32'h8000_0000, 32'h6, 3'b101, 7'h20, 1, 1, 32'hFE00_0000, 3);
    run("or",       1, 32'hF0, 32'h0F, 3'b110, 7'h00, 1, 0, 32'hFF, 1);
    run("and",      1, 32'hF0F0, 32'hFF00, 3'b111, 7'h00, 1, 0, 32'hF000, 1);

    // Request held through SHIFT, accepted in DONE, results back-to-back
    sel = 1; in_a = 32'h1; in_b = 32'h5; f3 = 3'b001; f7 = 7'h00; alu_en = 1; alu_imm = 0;
    valid4 = 1;
    @(posedge clk); #1;
    in_a = 32'h0000_F0F0; in_b = 32'h0000_0FF0; f3 = 3'b100;
    check("held_busy",  m_busy,  1'b1);
    check("held_ready", m_ready, 1'b0);
    @(posedge clk); #1;
    check("held_novalid", m_valid, 1'b0);
    @(posedge clk); #1;
    check("b2b_v1", m_valid, 1'b1);
    check("b2b_r1", m_out, 32'h0000_0020);
    @(posedge clk); #1; valid4 = 0;
    check("b2b_v2", m_valid, 1'b1);
    check("b2b_r2", m_out, 32'h0000_FF00);
    @(posedge clk); #1;
    check("b2b_idle", m_valid, 1'b0);

    // Kill in the third SHIFT cycle of a k=20 shift; prior result 0x1010 must survive
    sel = 0; in_a = 32'hFFFF_0000; in_b = 32'd20; f3 = 3'b101; f7 = 7'h00;
    valid1 = 1;
    @(posedge clk); #1; valid1 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("kill_busy_before", m_busy, 1'b1);
    kill = 1;
    @(posedge clk); #1; kill = 0;
    check("kill_busy",  m_busy,  1'b0);
    check("kill_ready", m_ready, 1'b1);
    check("kill_valid", m_valid, 1'b0);
    check("kill_out",   m_out,   32'h0000_1010);
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      if (m_valid) nv++;
      @(posedge clk); #1;
    end
    check("kill_novalid", nv, 0);

    // Kill in DONE: o_valid still high, request in that cycle dropped
    run("add_pre", 0, 32'h2, 32'h3, 3'b000, 7'h00, 1, 0, 32'h5, 1);
    in_a = 32'hFF; in_b = 32'h0F; f3 = 3'b100; valid1 = 1; kill = 1;
    #1;
    check("killdone_valid", m_valid, 1'b1);
    @(posedge clk); #1; kill = 0; valid1 = 0;
    check("killdone_idle", m_valid, 1'b0);
    check("killdone_out",  m_out,   32'h5);

    // Asynchronous reset in the middle of a shift
    in_a = 32'h8000_0000; in_b = 32'd31; f3 = 3'b101; f7 = 7'h20; valid1 = 1;
    @(posedge clk); #1; valid1 = 0;
    repeat (3) begin @(posedge clk); #1; end
    check("rstmid_busy_before", m_busy, 1'b1);
    #2; rst = 1;
    #1;
    check("rstmid_out",   m_out,   32'h0);
    check("rstmid_valid", m_valid, 1'b0);
    check("rstmid_busy",  m_busy,  1'b0);
    check("rstmid_ready", m_ready, 1'b1);
    #1; rst = 0;
    @(posedge clk); #1;
    check("rstmid_after_busy", m_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
